shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle controller that performs an N-position shift or rotate by stepping a 1-bit shift/rotate datapath once per clock.
- Accepts a command with a start pulse, runs for `amount` steps, then signals completion with a one-cycle `done` pulse and a held `result`.
- Sits between the ALU command decoder and the shift/rotate datapath. It serialises variable-distance shifts so the datapath stays single-bit.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 3, width of `amount` and the internal step counter; must equal clog2(WIDTH).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled on the rising edge only while the block is idle.
- abort  input  1  cancels a running command; sampled on the rising edge.
- operand  input  WIDTH  data to shift; latched when the command is accepted.
- op  input  2  operation: 00 shift left, fill 0; 01 shift right logical, fill 0; 10 rotate left; 11 rotate right.
- amount  input  CNT_W  number of 1-bit steps, 0 to WIDTH-1; latched when the command is accepted.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle completion pulse, high in DONE.
- result  output  WIDTH  working/result register.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, latched op=00. Reset mid-RUN discards the command and produces no done.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE, start=1 at edge: latch op, load result<=operand, counter<=amount.
  - Next state is RUN if amount!=0.
  - Next state is DONE if amount==0, with result=operand.
- IDLE, start=0: hold. result keeps its last value indefinitely.
- RUN, each edge: result<=one-step(result, op), counter<=counter-1.
  - When counter==1 at the edge, that step is the last and next state is DONE.
  - Otherwise stay in RUN.
- One-step definitions, where r is the current result:
  - op 00: {r[W-2:0],0}
  - op 01: {0,r[W-1:1]}
  - op 10: {r[W-2:0],r[W-1]}
  - op 11: {r[0],r[W-1:1]}
- DONE: done=1 and busy=1 for exactly one cycle; result is final and stable. Next edge goes to IDLE unconditionally.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E(amount). The total is amount+1 cycles, or 1 cycle for amount=0.
- start while busy=1 (RUN or DONE) is ignored; it is neither queued nor re-latched. Input changes to operand/op/amount during RUN have no effect.
- abort=1 in RUN: next edge goes to IDLE, no done pulse. result holds the partially shifted value and counter is cleared. abort has priority over completion on the same edge.
- abort in IDLE or DONE: no effect. DONE still returns to IDLE and done still pulses.
- start and abort both high in IDLE: start is accepted and abort is ignored.
- Back-to-back: earliest next accept is the edge following the DONE cycle, i.e. start held high from DONE is accepted in IDLE. Minimum command spacing is amount+2 cycles.
- amount is used modulo nothing; values 0..WIDTH-1 are all legal and no saturation is needed.

Test Plan:
- Reset then idle: hold rst_n=0, then release with start=0. -> busy=0, done=0, result=8'h00 for 10 cycles.
- Shift left: start with operand=8'h99, op=00, amount=1. -> busy high, done pulses 2 cycles after the accept edge, result=8'h32.
- Rotates:
  - operand=8'h99, op=11, amount=3 -> result=8'h33, done after 4 cycles.
  - operand=8'h81, op=10, amount=7 -> result=8'hC0, done after 8 cycles.
- Zero amount and busy start: operand=8'hA5, op=01, amount=0 -> done the next cycle, result=8'hA5. Then start a second command (8'h99, op=01, amount=4) and pulse start again during RUN with different data -> only the first is executed, result=8'h09, single done.
- Abort mid-run: operand=8'hF0, op=00, amount=5, abort at the 2nd RUN edge. -> no done, busy drops, state IDLE, result=8'hC0. A following command executes normally.
- Async reset mid-run: start amount=6, drop rst_n between edges in the 3rd RUN cycle. -> outputs clear immediately without a clock edge, and no done appears after release.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: steps a 1-bit shift/rotate datapath once
// per clock for `amount` steps, then pulses done with the result held.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_val;

    always_comb begin
        step_val = result_q;
        case (op_q)
            2'b00: step_val = {result_q[WIDTH-2:0], 1'b0};
            2'b01: step_val = {1'b0, result_q[WIDTH-1:1]};
            2'b10: step_val = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            2'b11: step_val = {result_q[0], result_q[WIDTH-1:1]};
            default: step_val = result_q;
        endcase
    end

    // The abort edge still performs its step, so an abort leaves the
    // partially shifted value including that edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    result_d = operand;
                    cnt_d    = amount;
                    state_d  = (amount != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                result_d = step_val;
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign state_o = state_q;

endmodule
